// File: rtl/stripe_arbiter.sv
// ---------------------------------------------------------------------------
// stripe_arbiter
//
// Round-robin burst arbiter that shares the byte-striping lane pair between
// two first-word-fall-through byte sources. A grant lasts up to MAX_BURST
// bytes. The first byte of every burst is placed on lane 0, so byte pairs
// across the two lanes always belong to the same source. The lane-phase
// toggle is exported so the downstream striper can steer each byte.
//
// Ports
//   clk_2f     in   byte-rate clock, rising edge
//   reset      in   asynchronous, active-low reset
//   req0/req1  in   source has a head byte available (FIFO not empty)
//   data0/1    in   source head byte, valid while its req is high
//   pop0/pop1  out  consume the source head byte this cycle (combinational)
//   data_out   out  byte to striper (registered)
//   valid_out  out  data_out valid (registered)
//   phase      out  lane of the current data_out: 0 = lane 0, 1 = lane 1
//   grant      out  one-hot current owner, 00 when idle
// ---------------------------------------------------------------------------
module stripe_arbiter #(
    parameter int BW        = 8,
    parameter int MAX_BURST = 4
) (
    input  logic          clk_2f,
    input  logic          reset,
    input  logic          req0,
    input  logic [BW-1:0] data0,
    output logic          pop0,
    input  logic          req1,
    input  logic [BW-1:0] data1,
    output logic          pop1,
    output logic [BW-1:0] data_out,
    output logic          valid_out,
    output logic          phase,
    output logic [1:0]    grant
);

    localparam int CW = $clog2(MAX_BURST) + 1;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ALIGN = 2'd1,
        BURST = 2'd2
    } state_t;

    state_t          state_reg, state_next;
    logic            owner_reg, owner_next;     // 0 = source 0, 1 = source 1
    logic            ptr_reg, ptr_next;         // last-served source
    logic [CW-1:0]   count_reg, count_next;     // bytes popped in this burst
    logic            phase_reg;
    logic [BW-1:0]   data_out_reg;
    logic            valid_out_reg;

    // Per-source views so the owner can index them directly.
    logic [1:0]      req_vec;
    logic [BW-1:0]   data_vec [2];
    logic [1:0]      pop_vec;
    logic            pop_any;
    logic            req_owner;
    logic [1:0]      grant_int;
    logic [CW-1:0]   count_inc;

    assign req_vec     = {req1, req0};
    assign data_vec[0] = data0;
    assign data_vec[1] = data1;

    genvar gi;
    generate
        for (gi = 0; gi < 2; gi++) begin : g_src
            // Only the current owner can ever be popped.
            assign pop_vec[gi] = pop_any && (owner_reg == 1'(gi));
        end
    endgenerate

    assign pop0      = pop_vec[0];
    assign pop1      = pop_vec[1];
    assign req_owner = req_vec[owner_reg];
    assign count_inc = count_reg + 1'b1;

    // -----------------------------------------------------------------------
    // Next-state and pop logic
    // -----------------------------------------------------------------------
    always_comb begin
        state_next = state_reg;
        owner_next = owner_reg;
        ptr_next   = ptr_reg;
        count_next = count_reg;
        pop_any    = 1'b0;
        grant_int  = 2'b00;

        case (state_reg)
            IDLE: begin
                if (|req_vec) begin
                    // On contention the source that was not served last wins;
                    // otherwise the single requester wins.
                    owner_next = (req_vec == 2'b11) ? ~ptr_reg : req_vec[1];
                    state_next = ALIGN;
                end
            end

            ALIGN: begin
                grant_int = owner_reg ? 2'b10 : 2'b01;
                if (!req_owner) begin
                    // Owner withdrew before its first byte: nothing was served,
                    // so the round-robin pointer is left alone.
                    state_next = IDLE;
                end else if (phase_reg) begin
                    // Popping on phase 1 places the registered byte on lane 0.
                    pop_any    = 1'b1;
                    count_next = CW'(1);
                    state_next = BURST;
                end
            end

            BURST: begin
                grant_int = owner_reg ? 2'b10 : 2'b01;
                if (req_owner) begin
                    pop_any    = 1'b1;
                    count_next = count_inc;
                    if (count_inc == CW'(MAX_BURST)) begin
                        state_next = IDLE;
                        ptr_next   = owner_reg;
                        count_next = '0;
                    end
                end else begin
                    // Source ran dry: end the burst short with no pad byte.
                    state_next = IDLE;
                    ptr_next   = owner_reg;
                    count_next = '0;
                end
            end

            default: begin
                state_next = IDLE;
                count_next = '0;
            end
        endcase
    end

    // -----------------------------------------------------------------------
    // State, lane phase and output register
    // -----------------------------------------------------------------------
    always_ff @(posedge clk_2f or negedge reset) begin
        if (!reset) begin
            state_reg     <= IDLE;
            owner_reg     <= 1'b0;
            ptr_reg       <= 1'b1;           // source 0 wins the first contest
            count_reg     <= '0;
            phase_reg     <= 1'b0;
            data_out_reg  <= '0;
            valid_out_reg <= 1'b0;
        end else begin
            state_reg     <= state_next;
            owner_reg     <= owner_next;
            ptr_reg       <= ptr_next;
            count_reg     <= count_next;
            phase_reg     <= ~phase_reg;     // free-running lane toggle
            valid_out_reg <= pop_any;
            if (pop_any) begin
                data_out_reg <= data_vec[owner_reg];
            end
        end
    end

    assign data_out  = data_out_reg;
    assign valid_out = valid_out_reg;
    assign phase     = phase_reg;
    assign grant     = grant_int;

endmodule

// File: tb/tb_stripe_arbiter.sv
// ---------------------------------------------------------------------------
// tb_stripe_arbiter
//
// Self-checking bench for stripe_arbiter. The two byte sources are modelled
// as FWFT FIFOs (head byte + occupancy). Directed per-cycle tables cover the
// alternating, short-burst and single-cycle-request cases; hand sequences
// cover idle after reset and an asynchronous reset mid-burst; a randomized
// phase is checked against burst-level rules (ordering, lane alignment,
// burst length, round-robin handover, starvation bound).
// ---------------------------------------------------------------------------
module tb_stripe_arbiter;

    localparam int BW = 8;
    localparam int MB = 4;

    logic          clk_2f = 1'b0;
    logic          reset  = 1'b0;
    logic          req0, req1;
    logic [BW-1:0] data0, data1;
    logic          pop0, pop1;
    logic [BW-1:0] data_out;
    logic          valid_out;
    logic          phase;
    logic [1:0]    grant;

    // FWFT source models
    logic          en0 = 1'b0, en1 = 1'b0;
    int unsigned   avail0 = 0, avail1 = 0;
    logic [7:0]    head0 = 8'h00, head1 = 8'h00;

    assign req0  = en0 && (avail0 != 0);
    assign req1  = en1 && (avail1 != 0);
    assign data0 = head0;
    assign data1 = head1;

    always #5 clk_2f = ~clk_2f;

    stripe_arbiter #(.BW(BW), .MAX_BURST(MB)) dut (
        .clk_2f    (clk_2f),
        .reset     (reset),
        .req0      (req0),
        .data0     (data0),
        .pop0      (pop0),
        .req1      (req1),
        .data1     (data1),
        .pop1      (pop1),
        .data_out  (data_out),
        .valid_out (valid_out),
        .phase     (phase),
        .grant     (grant)
    );

    int total = 0;
    int bad   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic adv0();
        if (avail0 != 0) begin
            head0++;
            avail0--;
        end
    endtask

    task automatic adv1();
        if (avail1 != 0) begin
            head1++;
            avail1--;
        end
    endtask

    // Hold reset for two edges, release just after a rising edge.
    task automatic do_reset();
        en0    = 1'b0;
        en1    = 1'b0;
        reset  = 1'b0;
        avail0 = 0;
        avail1 = 0;
        @(posedge clk_2f);
        @(posedge clk_2f);
        #1 reset = 1'b1;
    endtask

    // One cycle without checks: sample pops, consume after the edge.
    task automatic step();
        logic s0, s1;
        @(negedge clk_2f);
        s0 = pop0;
        s1 = pop1;
        @(posedge clk_2f);
        #1;
        if (s0) adv0();
        if (s1) adv1();
    endtask

    // ---------------------------------------------------------------------
    // Directed per-cycle table
    // ---------------------------------------------------------------------
    typedef struct {
        int         scen;
        bit         e0, e1;
        bit         v;
        logic [7:0] d;
        bit         ph;
        logic [1:0] g;
        bit         p0, p1;
    } row_t;

    row_t tbl[$];

    task automatic add(input int s, input bit e0, input bit e1, input bit v,
                       input logic [7:0] d, input bit ph, input logic [1:0] g,
                       input bit p0, input bit p1);
        row_t r;
        r.scen = s; r.e0 = e0; r.e1 = e1; r.v = v; r.d = d;
        r.ph = ph; r.g = g; r.p0 = p0; r.p1 = p1;
        tbl.push_back(r);
    endtask

    task automatic setup(input int s);
        case (s)
            0: begin head0 = 8'h10; avail0 = 1000; head1 = 8'h80; avail1 = 1000; end
            1: begin head0 = 8'hA0; avail0 = 3;    head1 = 8'hB0; avail1 = 1000; end
            default: begin head0 = 8'h30; avail0 = 1000; head1 = 8'hC0; avail1 = 1000; end
        endcase
    endtask

    // ---------------------------------------------------------------------
    // Randomized phase state
    // ---------------------------------------------------------------------
    bit         ph_exp;
    bit         pv_pop, pv_valid, pv_src;
    logic [7:0] pv_byte;
    int         run_src, run_len;
    bit         have_full, full_busy;
    int         full_src;
    int         wait0, wait1;
    int         gen_cnt, out_cnt;

    task automatic rand_cycle(input int rate0, input int rate1);
        logic s0, s1;
        @(negedge clk_2f);
        s0 = pop0;
        s1 = pop1;
        check("rnd_phase", phase, ph_exp);
        check("rnd_valid", valid_out, pv_pop);
        if (pv_pop) begin
            check("rnd_data", data_out, pv_byte);
            out_cnt++;
        end
        check("rnd_pop_excl", s0 & s1, 0);
        check("rnd_grant_legal", (grant == 2'b11), 0);
        if (s0) check("rnd_pop0_legal", req0 && (grant == 2'b01), 1);
        if (s1) check("rnd_pop1_legal", req1 && (grant == 2'b10), 1);

        if (valid_out) begin
            if (!pv_valid) begin
                // A new burst begins: lane 0, and a full burst hands over to
                // the other source whenever that source was waiting.
                check("rnd_burst_lane0", phase, 0);
                run_src = int'(pv_src);
                run_len = 1;
                if (have_full && full_busy)
                    check("rnd_round_robin", (run_src != full_src), 1);
                have_full = 1'b0;
            end else begin
                check("rnd_same_src", int'(pv_src), run_src);
                run_len++;
                check("rnd_burst_len", (run_len > MB), 0);
            end
            if (run_len == MB) begin
                have_full = 1'b1;
                full_src  = run_src;
                full_busy = (run_src == 0) ? (avail1 != 0) : (avail0 != 0);
            end
        end

        wait0 = (avail0 != 0 && !s0) ? wait0 + 1 : 0;
        wait1 = (avail1 != 0 && !s1) ? wait1 + 1 : 0;
        check("rnd_starve0", (wait0 > 16), 0);
        check("rnd_starve1", (wait1 > 16), 0);

        pv_valid = valid_out;
        pv_pop   = s0 | s1;
        pv_src   = s1;
        pv_byte  = s0 ? head0 : head1;

        @(posedge clk_2f);
        #1;
        if (s0) adv0();
        if (s1) adv1();
        if ($urandom_range(0, 99) < rate0) begin avail0++; gen_cnt++; end
        if ($urandom_range(0, 99) < rate1) begin avail1++; gen_cnt++; end
        ph_exp = ~ph_exp;
    endtask

    int rates0[4] = '{40, 15, 30, 5};
    int rates1[4] = '{40, 10, 30, 5};

    initial begin
        int  cur;
        logic s0, s1;

        // Scenario 0: both sources always requesting -> alternating bursts.
        add(0,1,1, 0,8'h00,0,2'b00,0,0);
        add(0,1,1, 0,8'h00,1,2'b01,1,0);
        add(0,1,1, 1,8'h10,0,2'b01,1,0);
        add(0,1,1, 1,8'h11,1,2'b01,1,0);
        add(0,1,1, 1,8'h12,0,2'b01,1,0);
        add(0,1,1, 1,8'h13,1,2'b00,0,0);
        add(0,1,1, 0,8'h13,0,2'b10,0,0);
        add(0,1,1, 0,8'h13,1,2'b10,0,1);
        add(0,1,1, 1,8'h80,0,2'b10,0,1);
        add(0,1,1, 1,8'h81,1,2'b10,0,1);
        add(0,1,1, 1,8'h82,0,2'b10,0,1);
        add(0,1,1, 1,8'h83,1,2'b00,0,0);
        add(0,1,1, 0,8'h83,0,2'b01,0,0);
        add(0,1,1, 0,8'h83,1,2'b01,1,0);
        add(0,1,1, 1,8'h14,0,2'b01,1,0);
        add(0,1,1, 1,8'h15,1,2'b01,1,0);
        // Scenario 1: source 0 holds only 3 bytes -> short burst, source 1 realigns.
        add(1,1,1, 0,8'h00,0,2'b00,0,0);
        add(1,1,1, 0,8'h00,1,2'b01,1,0);
        add(1,1,1, 1,8'hA0,0,2'b01,1,0);
        add(1,1,1, 1,8'hA1,1,2'b01,1,0);
        add(1,1,1, 1,8'hA2,0,2'b01,0,0);
        add(1,1,1, 0,8'hA2,1,2'b00,0,0);
        add(1,1,1, 0,8'hA2,0,2'b10,0,0);
        add(1,1,1, 0,8'hA2,1,2'b10,0,1);
        add(1,1,1, 1,8'hB0,0,2'b10,0,1);
        add(1,1,1, 1,8'hB1,1,2'b10,0,1);
        // Scenario 2: one-cycle req0 pulse in IDLE, then contention still goes to source 0.
        add(2,1,0, 0,8'h00,0,2'b00,0,0);
        add(2,0,0, 0,8'h00,1,2'b01,0,0);
        add(2,1,1, 0,8'h00,0,2'b00,0,0);
        add(2,1,1, 0,8'h00,1,2'b01,1,0);
        add(2,1,1, 1,8'h30,0,2'b01,1,0);

        // Idle after reset: no activity, phase toggles from 0.
        do_reset();
        for (int c = 0; c < 10; c++) begin
            @(negedge clk_2f);
            check($sformatf("idle%0d_valid", c), valid_out, 0);
            check($sformatf("idle%0d_grant", c), grant, 0);
            check($sformatf("idle%0d_pops", c), {pop1, pop0}, 0);
            check($sformatf("idle%0d_phase", c), phase, c % 2);
            @(posedge clk_2f);
        end

        // Table-driven sequences
        cur = -1;
        for (int i = 0; i < tbl.size(); i++) begin
            if (tbl[i].scen != cur) begin
                cur = tbl[i].scen;
                do_reset();
                setup(cur);
            end
            en0 = tbl[i].e0;
            en1 = tbl[i].e1;
            @(negedge clk_2f);
            check($sformatf("t%0d_valid", i), valid_out, tbl[i].v);
            check($sformatf("t%0d_data", i), data_out, tbl[i].d);
            check($sformatf("t%0d_phase", i), phase, tbl[i].ph);
            check($sformatf("t%0d_grant", i), grant, tbl[i].g);
            check($sformatf("t%0d_pop0", i), pop0, tbl[i].p0);
            check($sformatf("t%0d_pop1", i), pop1, tbl[i].p1);
            s0 = pop0;
            s1 = pop1;
            @(posedge clk_2f);
            #1;
            if (s0) adv0();
            if (s1) adv1();
        end

        // Asynchronous reset after two bytes of a burst.
        do_reset();
        head0 = 8'h10; avail0 = 1000; en0 = 1'b1;
        step(); step(); step();
        @(negedge clk_2f);
        check("rst_pre_data", data_out, 8'h11);
        check("rst_pre_pop0", pop0, 1);
        #2 reset = 1'b0;
        #1;
        check("rst_async_valid", valid_out, 0);
        check("rst_async_data", data_out, 0);
        check("rst_async_pops", {pop1, pop0}, 0);
        check("rst_async_grant", grant, 0);
        check("rst_async_phase", phase, 0);
        @(posedge clk_2f);
        @(posedge clk_2f);
        #1 reset = 1'b1;
        @(negedge clk_2f);
        check("rst_after_pop0", pop0, 0);
        check("rst_after_valid", valid_out, 0);
        @(posedge clk_2f);
        #1;
        @(negedge clk_2f);
        check("rst_after_align_pop", pop0, 1);
        check("rst_after_align_phase", phase, 1);
        @(posedge clk_2f);
        #1 adv0();
        @(negedge clk_2f);
        check("rst_after_first_data", data_out, 8'h12);
        check("rst_after_first_phase", phase, 0);
        check("rst_after_first_valid", valid_out, 1);
        @(posedge clk_2f);
        #1;

        // Randomized traffic
        do_reset();
        head0 = 8'h00; head1 = 8'h80;
        en0 = 1'b1; en1 = 1'b1;
        ph_exp = 1'b0; pv_pop = 1'b0; pv_valid = 1'b0; pv_src = 1'b0; pv_byte = '0;
        run_src = 0; run_len = 0; have_full = 1'b0; full_busy = 1'b0; full_src = 0;
        wait0 = 0; wait1 = 0; gen_cnt = 0; out_cnt = 0;
        for (int c = 0; c < 3000; c++) begin
            rand_cycle(rates0[c / 750], rates1[c / 750]);
        end
        for (int c = 0; c < 4000 && (avail0 != 0 || avail1 != 0); c++) begin
            rand_cycle(0, 0);
        end
        for (int c = 0; c < 4; c++) begin
            rand_cycle(0, 0);
        end
        check("rnd_drained", avail0 + avail1, 0);
        check("rnd_all_out", out_cnt, gen_cnt);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/stripe_arbiter.md
Name: stripe_arbiter

Overview:
- Shares the byte-striping lane pair between two byte sources (FWFT FIFOs) using round-robin bursts.
- Drives the striper's data/valid input at the clk_2f rate.
- Every burst's first byte lands on lane 0, so byte pairs stay lane-aligned.
- Sits directly upstream of the striper in phy_tx. Exports its lane-phase counter for the striper's selector.

Parameters:
- BW, 8, byte width of data paths.
- MAX_BURST, 4, maximum bytes per grant; must be even and >= 2.

Ports:
- clk_2f  in  1  byte-rate clock, rising edge.
- reset  in  1  asynchronous, active-low reset.
- req0  in  1  source 0 has a byte available (FIFO not empty).
- data0  in  BW  source 0 head byte, valid while req0=1.
- pop0  out  1  consume source 0 head byte this cycle.
- req1  in  1  as req0, source 1.
- data1  in  BW  as data0, source 1.
- pop1  out  1  as pop0, source 1.
- data_out  out  BW  byte to striper (registered).
- valid_out  out  1  data_out valid (registered).
- phase  out  1  lane of current data_out: 0=lane 0, 1=lane 1.
- grant  out  2  one-hot current owner; 00 when idle.

Behaviour:
- Reset (reset=0, async):
  - data_out=0, valid_out=0, pop0=pop1=0, grant=00, phase=0.
  - state=IDLE, burst count=0, last-served pointer=1 (source 0 wins first).
  - Reset mid-burst aborts immediately: no further pops; the partial burst is discarded downstream.
- phase is a free-running toggle: 0 in the first cycle after reset release, then inverts every clk_2f edge.
- Output register:
  - pop asserted at cycle t => data_out/valid_out at t+1 carry the popped byte, valid_out=1.
  - Otherwise valid_out=0 and data_out holds its last value.
- Pops are combinational from state, owner, req and phase. pop0 and pop1 are never both 1.
- State IDLE:
  - grant=00.
  - If any req: pick the winner round-robin (prefer the source other than the last-served pointer when both request), latch it as owner, go to ALIGN.
  - No pop in IDLE.
- State ALIGN:
  - grant=owner.
  - If req_owner=1 and phase=1: pop owner, count=1, go to BURST. The byte appears at t+1 with phase=0, i.e. lane 0.
  - If req_owner=0: go to IDLE, no pop; the pointer is unchanged.
  - Otherwise hold.
- State BURST:
  - grant=owner.
  - If req_owner=1: pop, count+1. When count reaches MAX_BURST, go to IDLE and set pointer=owner.
  - If req_owner=0: burst ends short, go to IDLE, pointer=owner. No pad byte is generated.
- Alignment rules:
  - A short burst may end on lane 0; the following burst still waits in ALIGN for phase=1.
  - Full bursts always end on lane 1 because MAX_BURST is even.
- Back-to-back throughput: a full burst is followed by the IDLE and ALIGN cycles (>=2 idle byte slots) before the next burst's first output.
- Count width is clog2(MAX_BURST)+1; count never exceeds MAX_BURST.
- Simultaneous req drop and last pop: the count limit takes priority; both paths end in IDLE with pointer=owner.

Test Plan:
- Reset then idle, all req=0 for 10 cycles -> valid_out=0, grant=00, pop0=pop1=0, phase alternates 0,1,0,1 starting at 0.
- req0=1 constant, data0 incrementing from 0x10, MAX_BURST=4 -> bytes 0x10..0x13 emitted with phase 0,1,0,1; then >=2 invalid slots; the next burst starts at phase 0 with 0x14.
- req0=req1=1 constant after reset -> bursts alternate src0 (4 bytes), src1 (4 bytes), src0, and so on. grant is one-hot and matches the source; pop is never on both sources in the same cycle.
- Short burst: src0 has 3 bytes 0xA0..0xA2 then req0=0, req1=1 with 0xB0.. -> 0xA0/0xA1/0xA2 on phases 0/1/0; src1 waits in ALIGN; 0xB0 emitted on phase 0.
- req0 pulses high for 1 cycle, in IDLE only -> grant=01 for at least 1 cycle, then back to 00; no pop and no valid_out; the next simultaneous request still goes to src0.
- reset asserted mid-burst after 2 bytes -> all outputs 0 the same cycle (async). After release, no residual pop; the first new burst starts on phase 0.
